sequence_counter: RTL and testbench
===================================

# sequence_counter

Sequence counter for the basic-computer control unit. It holds the current micro-step index and presents it as a one-hot timing vector `T` (T0…T15). The controller uses `T` to select fetch/decode/execute micro-operations and drives `INR`/`CLR` back into this block, combinationally from `T` and the decoded instruction.

## Interface
- `WIDTH`, default 16: number of timing states; width of `T`; legal range 2…16.
- `CNT_W`, default `$clog2(WIDTH)` (4): width of the internal binary count.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `CLR`  in  1: synchronous clear; next step is T0.
- `INR`  in  1: synchronous increment; advance to the next step.
- `T`  out  WIDTH: one-hot timing signals; `T[k]`=1 while count==k.
- `COUNT`  out  CNT_W: binary step index, for debug and trace.

## Operation
- State is a CNT_W-bit register `cnt`.
- Next-state priority, evaluated at each rising `clk`:
  - `CLR`=1: `cnt`←0. CLR beats INR when both are high.
  - else `INR`=1: `cnt`←`cnt`+1, except at `cnt`==WIDTH-1, where `cnt`←0 (wrap).
  - else: hold.
- `T` = one-hot decode of `cnt`. Exactly one bit is set at all times, including during and after reset.
- If `cnt` ever holds a value ≥ WIDTH (only possible when WIDTH is not a power of two), the next clock forces `cnt`←0 regardless of INR/CLR. While in that state, `T` is all-zero.
- `COUNT` = `cnt`, directly.
- No other inputs. X on INR/CLR is not required to be handled.

## Timing
- Reset: `rst_n`=0 immediately forces `cnt`=0, so `T`=0x0001 and `COUNT`=0. This holds without a clock edge and persists while `rst_n` is low. INR/CLR are ignored during reset.
- Reset deassertion: the first rising edge with `rst_n`=1 samples INR/CLR normally.
- Latency: INR/CLR sampled at edge n are reflected on `T`/`COUNT` just after edge n. There are no extra pipeline stages.
- `T` is a purely combinational decode of the register, with no inputs feeding forward. The controller may therefore derive INR/CLR from `T` combinationally without a loop.
- INR held high continuously walks T0→T1→…→T(WIDTH-1)→T0, one step per cycle.
- Reset asserted mid-sequence (e.g. at T3) returns to T0 asynchronously. The sequence restarts from T0 after release.

## Structure
- Shared package `sc_pkg` holds:
  - `SC_STATES` = 16.
  - `SC_CNT_W` = 4.
  - Named step constants `T_FETCH0`=0, `T_FETCH1`=1, `T_DECODE`=2, `T_EXEC0`=3, so the controller and bench index `T` symbolically.
- Sub-module `sc_decoder` holds the parameterised binary→one-hot decoder: CNT_W in, WIDTH out, zero output for out-of-range input.
- The top contains the counter register, next-state logic, and one `sc_decoder` instance.
- Optional assertions, disabled in synthesis:
  - `$onehot(T)` whenever `rst_n`=1 and `cnt`<WIDTH.
  - `T` must equal `1<<COUNT`.

## Test plan
- Reset: `rst_n`=0 from an arbitrary state (`cnt`=5) → `T`=0x0001 and `COUNT`=0 before any clock edge; they hold while reset is low, even with INR=1.
- Increment walk: after reset, INR=1 for 3 cycles → `T` = 0x0002, 0x0004, 0x0008 on successive edges; `COUNT`=3.
- Hold: at `COUNT`=3, INR=CLR=0 for 5 cycles → `T` stays 0x0008.
- Clear and priority: at `COUNT`=3 with INR=1 and CLR=1 → next edge `T`=0x0001; CLR alone from `COUNT`=7 → 0x0001.
- Wrap: INR=1 for 16 cycles from T0 → passes through 0x8000 at cycle 15, then returns to 0x0001 at cycle 16.
- Controller-style loop: INR driven combinationally from T0|T1|T2 and CLR from T3 → the sequence repeats T0,T1,T2,T3,T0,… with period 4. `T` is one-hot every cycle.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared constants for the basic-computer sequence counter and its users.
package sc_pkg;

  localparam int SC_STATES = 16;
  localparam int SC_CNT_W  = 4;

  // Symbolic step indices so the controller indexes T by name.
  localparam int T_FETCH0 = 0;
  localparam int T_FETCH1 = 1;
  localparam int T_DECODE = 2;
  localparam int T_EXEC0  = 3;

endpackage

// File: rtl/sc_decoder.sv
// Binary-to-one-hot decoder; an input that matches no output bit yields all zeros.
module sc_decoder #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic [CNT_W-1:0] bin,
  output logic [WIDTH-1:0] onehot
);

  // One comparator per output bit; out-of-range codes match none of them.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    assign onehot[k] = (bin == CNT_W'(k));
  end

endmodule

// File: rtl/sequence_counter.sv
// Micro-step sequence counter: binary step register plus one-hot timing decode.
// T is a pure decode of the register so the controller may build INR/CLR
// combinationally from T without forming a loop.
module sequence_counter
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_STATES,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CLR,
  input  logic             INR,
  output logic [WIDTH-1:0] T,
  output logic [CNT_W-1:0] COUNT
);

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W:0]   LIMIT = (CNT_W + 1)'(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic             out_of_range;

  // Only reachable for non power-of-two WIDTH; recovered on the next edge.
  assign out_of_range = ({1'b0, cnt} >= LIMIT);

  // Step register: recovery beats CLR, CLR beats INR, INR wraps at the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (out_of_range) cnt <= '0;
    else if (CLR)          cnt <= '0;
    else if (INR)          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign COUNT = cnt;

  sc_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dec (
    .bin    (cnt),
    .onehot (T)
  );

`ifndef SYNTHESIS
  // Timing vector stays one-hot for every legal step.
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !out_of_range |-> $onehot(T));
  // Decode always agrees with the binary index.
  a_decode: assert property (@(posedge clk) disable iff (!rst_n)
    T == (WIDTH'(1) << COUNT));
`endif

endmodule

// File: tb/tb_sequence_counter.sv
// Self-checking bench for sequence_counter: directed scenarios plus random
// INR/CLR traffic against an arithmetic step model.
module tb_sequence_counter;
  import sc_pkg::*;

  localparam int W  = SC_STATES;
  localparam int CW = SC_CNT_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inr_drv, clr_drv, ctl_mode;
  logic          INR, CLR;
  logic [W-1:0]  T;
  logic [CW-1:0] COUNT;

  int vectors = 0;
  int miscompares = 0;
  int m = 0;   // reference step index

  always #5 clk = ~clk;

  // Controller-style feedback when ctl_mode is set, direct drive otherwise.
  assign INR = ctl_mode ? (T[T_FETCH0] | T[T_FETCH1] | T[T_DECODE]) : inr_drv;
  assign CLR = ctl_mode ? T[T_EXEC0] : clr_drv;

  sequence_counter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .CLR   (CLR),
    .INR   (INR),
    .T     (T),
    .COUNT (COUNT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".T"}, 32'(T), 32'(1) << m);
    chk({tag, ".COUNT"}, 32'(COUNT), 32'(m));
  endtask

  // Apply one cycle of INR/CLR, advance the model, check just after the edge.
  task automatic step(input string tag, input logic inr, input logic clr);
    inr_drv = inr;
    clr_drv = clr;
    @(posedge clk);
    if (rst_n) begin
      if (clr)      m = 0;
      else if (inr) m = (m + 1) % W;
    end
    #1;
    chk_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; inr_drv = 1'b0; clr_drv = 1'b0; ctl_mode = 1'b0;
    #1;
    chk_state("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Climb to step 5, then assert reset asynchronously between edges.
    for (int i = 0; i < 5; i++) step("climb", 1'b1, 1'b0);
    rst_n = 1'b0; m = 0;
    #1;
    chk_state("async_rst");
    for (int i = 0; i < 3; i++) step("rst_hold_inr", 1'b1, 1'b0);
    rst_n = 1'b1;

    // Increment walk, hold, clear priority.
    for (int i = 0; i < 3; i++) step("walk", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0);
    step("clr_beats_inr", 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step("to7", 1'b1, 1'b0);
    step("clr_alone", 1'b0, 1'b1);

    // Full wrap from T0.
    for (int i = 0; i < W; i++) step("wrap", 1'b1, 1'b0);

    // Reset mid-sequence at T3, then restart.
    for (int i = 0; i < 3; i++) step("pre_mid", 1'b1, 1'b0);
    rst_n = 1'b0; m = 0;
    #1;
    chk_state("mid_rst");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) step("post_mid", 1'b1, 1'b0);

    // Controller loop: T0..T2 increment, T3 clears -> period 4.
    step("pre_ctl", 1'b0, 1'b1);
    ctl_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      m = (m == T_EXEC0) ? 0 : m + 1;
      #1;
      chk_state("ctl_loop");
      chk("ctl_onehot", 32'($onehot(T)), 32'd1);
    end
    ctl_mode = 1'b0;

    // Random INR/CLR traffic, INR-biased so wraps occur.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
